// File: rtl/mux_arb.sv
// mux_arb: N-channel fixed-priority/round-robin arbiter into one registered output stage (in_* valid/ready per channel, out_* valid/ready with source index).
module mux_arb #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int MODE = 1,
  localparam int SELW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SELW-1:0] ptr, g;
  logic hit, load;
  int idx;
  assign load = !out_valid || out_ready;
  always_comb begin
    g = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = ((MODE == 1 ? int'(ptr) : 0) + k) % CHANNELS;
      if (!hit && |(in_valid & (CHANNELS'(1) << idx))) begin
        hit = 1'b1;
        g = SELW'(idx);
      end
    end
  end
  assign in_ready = {CHANNELS{hit & load}} & (CHANNELS'(1) << g);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= in_data[int'(g)*WIDTH +: WIDTH];
        out_sel <= g;
        ptr <= int'(g) == CHANNELS - 1 ? '0 : g + 1'b1;
      end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed checks of round-robin, fixed-priority and single-channel arbiter variants.
module tb_mux_arb;
  logic clk = 1'b0, rst_n;
  logic [63:0] id1, id0;
  logic [3:0] iv1, ir1, iv0, ir0;
  logic [15:0] od1, od0;
  logic [1:0] os1, os0;
  logic ov1, or1, ov0, or0;
  logic [7:0] idp, odp;
  logic ivp, irp, ovp, orp, ain, aout;
  logic [0:0] osp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .in_data(id1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(or1));
  mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .in_data(id0), .in_valid(iv0), .in_ready(ir0),
    .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(or0));
  mux_arb #(.WIDTH(8), .CHANNELS(1), .MODE(1)) u_one (.clk(clk), .rst_n(rst_n), .in_data(idp), .in_valid(ivp), .in_ready(irp),
    .out_data(odp), .out_sel(osp), .out_valid(ovp), .out_ready(orp));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cur, exp;
    rst_n = 1'b0;
    {iv1, id1, or1, iv0, id0, or0, ivp, idp, orp} = '0;
    #2;
    chk("rst_ov", ov1, 0);
    chk("rst_od", od1, 0);
    chk("rst_os", os1, 0);
    chk("rst_ir", ir1, 0);
    tick();
    rst_n = 1'b1;
    iv1 = 4'hf;
    for (int i = 0; i < 4; i++) id1[i*16 +: 16] = 16'h00a0 + 16'(i);
    or1 = 1'b1;
    #1 chk("rr_ir0", ir1, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rr_sel", os1, c % 4);
      chk("rr_ov", ov1, 1);
      chk("rr_od", od1, 16'h00a0 + c % 4);
    end
    iv1 = 4'h0;
    tick();
    chk("drain_ov", ov1, 0);
    iv1 = 4'b0100;
    id1[32 +: 16] = 16'h1234;
    #1 chk("bp_ir", ir1, 4'b0100);
    tick();
    chk("bp_load_od", od1, 16'h1234);
    chk("bp_load_os", os1, 2);
    or1 = 1'b0;
    iv1 = 4'hf;
    for (int c = 0; c < 5; c++) begin
      id1 = {$urandom, $urandom};
      #1 chk("bp_ir0", ir1, 0);
      tick();
      chk("bp_od", od1, 16'h1234);
      chk("bp_os", os1, 2);
      chk("bp_ov", ov1, 1);
    end
    id1[0 +: 16] = 16'h0c00;
    id1[48 +: 16] = 16'h0c03;
    iv1 = 4'b0001;
    or1 = 1'b1;
    #1 chk("wrap_ir0", ir1, 4'b0001);
    tick();
    chk("wrap_os0", os1, 0);
    chk("wrap_od0", od1, 16'h0c00);
    iv1 = 4'b1001;
    #1 chk("wrap_ir3", ir1, 4'b1000);
    tick();
    chk("wrap_os3", os1, 3);
    chk("wrap_od3", od1, 16'h0c03);
    iv1 = 4'hf;
    #1 chk("wrap_ptr0", ir1, 4'b0001);
    tick();
    chk("pre_rst_os", os1, 0);
    or1 = 1'b0;
    #1 chk("hold_ir", ir1, 0);
    rst_n = 1'b0;
    #3;
    chk("arst_ov", ov1, 0);
    chk("arst_od", od1, 0);
    chk("arst_os", os1, 0);
    chk("arst_ir", ir1, 4'b0001);
    rst_n = 1'b1;
    or1 = 1'b1;
    tick();
    chk("post_rst_os", os1, 0);
    chk("post_rst_ov", ov1, 1);
    iv1 = 4'h0;
    iv0 = 4'b1010;
    id0[16 +: 16] = 16'h0b01;
    id0[48 +: 16] = 16'h0b03;
    or0 = 1'b1;
    #1 chk("fp_ir", ir0, 4'b0010);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fp_os", os0, 1);
      chk("fp_od", od0, 16'h0b01);
      chk("fp_ov", ov0, 1);
      chk("fp_ir", ir0, 4'b0010);
    end
    iv0 = 4'h0;
    cur = 1;
    exp = 1;
    for (int c = 0; c < 300 && exp <= 16; c++) begin
      ivp = cur <= 16;
      idp = 8'(cur);
      orp = 1'($urandom_range(0, 1));
      #1;
      ain = ivp & irp;
      aout = ovp & orp;
      if (aout) begin
        chk("p_od", odp, exp);
        chk("p_os", osp, 0);
      end
      tick();
      if (aout) exp++;
      if (ain) begin
        chk("p_lat_ov", ovp, 1);
        chk("p_lat_od", odp, cur);
        cur++;
      end
    end
    chk("p_count", exp, 17);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal range 1..16.
REQ-003 SHALL have parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-004 SHALL have localparam SELW = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, CHANNELS bits: channel i offers a word.
REQ-009 SHALL have port in_ready, output, CHANNELS bits: channel i word accepted this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: registered selected word.
REQ-011 SHALL have port out_sel, output, SELW bits: index of the channel that supplied out_data.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data/out_sel hold a word.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the word this cycle.

Function
REQ-014 Input transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Output register SHALL be "loadable" in a cycle iff out_valid==0 or out_ready==1.
REQ-016 in_ready SHALL be combinational and one-hot or zero: only the granted channel sees 1, and only when the register is loadable and that channel's in_valid is 1.
REQ-017 in_ready[i] SHALL NOT depend on in_data; no in_valid-to-in_valid combinational path other than through grant.
REQ-018 MODE 0: grant SHALL go to the lowest-index channel with in_valid=1.
REQ-019 MODE 1: grant SHALL go to the first channel with in_valid=1 searching upward from pointer ptr, wrapping from CHANNELS-1 to 0.
REQ-020 MODE 1: on an input transfer from channel g, ptr SHALL become g+1, wrapping to 0 after CHANNELS-1; ptr SHALL be unchanged when no transfer occurs.
REQ-021 On input transfer, out_data SHALL load in_data of channel g, out_sel SHALL load g, and out_valid SHALL be 1 the next cycle; latency input-to-output = 1 cycle.
REQ-022 Output transfer with no simultaneous input transfer SHALL clear out_valid next cycle.
REQ-023 Simultaneous output and input transfer SHALL reload the register with no bubble; sustained throughput = 1 word/cycle.
REQ-024 While out_valid==1 and out_ready==0, out_data, out_sel, out_valid SHALL hold stable and all in_ready SHALL be 0.
REQ-025 in_valid deasserted without transfer SHALL have no effect on ptr or output.
REQ-026 CHANNELS==1: SHALL behave as a one-entry pipeline register; out_sel constant 0; MODE ignored.
REQ-027 Word order per channel SHALL be preserved; no word SHALL be duplicated or dropped except by reset.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk, force out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready SHALL then follow REQ-016 with an empty register.
REQ-029 Reset asserted mid-operation SHALL discard any held word; the first grant after release SHALL follow REQ-018/019 with ptr=0.
REQ-030 Deassertion of rst_n SHALL take effect at the next rising edge; no transfer SHALL occur on the edge where rst_n is low.

Verification
REQ-031 MODE 1, CHANNELS=4, all in_valid=1, data i = 16'h00A0+i, out_ready=1: out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 MODE 0, in_valid=4'b1010, out_ready=1: every transfer from channel 1, in_ready=4'b0010, channel 3 starved.
REQ-033 Backpressure: load word 16'h1234 from channel 2, hold out_ready=0 for 5 cycles while changing in_data: out_data=16'h1234, out_sel=2, in_ready=0 throughout.
REQ-034 Wrap: ptr=3, in_valid=4'b0001: grant channel 0, ptr becomes 1; then in_valid=4'b1001: grant channel 3, ptr becomes 0.
REQ-035 Async reset: pulse rst_n low for 3 ns between edges with out_valid=1: out_valid=0, out_data=0 before the next edge; next grant starts at channel 0.
REQ-036 CHANNELS=1, WIDTH=8: stream 8'h01..8'h10 with random out_ready: output sequence identical, 1-cycle latency.
